dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Memory-stage initiator for the RV32 5-stage pipeline. It turns M-stage load/store requests into a multi-cycle req/ack data-bus transaction and raises MemStallM until the access completes. The hazard logic consumes MemStallM as an additional stall source that freezes F/D/E/M and bubbles W. The block also lane-aligns and sign-extends load data, and generates byte enables for stores.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of BUSY cycles waiting for bus_ack before the access is aborted with BusErrM
TMO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
MemReqM  in  1  a load or store is valid in the M stage
MemWriteM  in  1  1 = store, 0 = load
Funct3M  in  3  size/sign code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
ALUResultM  in  32  byte address
WriteDataM  in  32  store data, right-justified
ReadDataM  out  32  formatted load result, valid in DONE
MemStallM  out  1  stall request to the hazard logic
MisalignM  out  1  misaligned access flag (combinational)
BusErrM  out  1  timeout flag, valid in DONE
bus_req  out  1  bus request
bus_we  out  1  bus write enable
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  out  32  store data replicated across byte lanes
bus_be  out  4  byte enables
bus_ack  in  1  transaction complete
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset enters IDLE.
- Reset values: bus_req=0; bus_we=0; bus_addr=0; bus_wdata=0; bus_be=0; captured read-data register=0; BusErrM=0; timeout counter=0.
- Misaligned access: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0.
  - MisalignM is asserted combinationally while in IDLE.
  - No transaction is issued, MemStallM=0, and the FSM stays in IDLE.
- IDLE, when MemReqM=1 and the access is aligned:
  - MemStallM=1 combinationally.
  - Register addr, we, be and wdata into the bus output registers; clear the counter; next state is BUSY.
- BUSY:
  - bus_req=1, MemStallM=1; all bus outputs are held stable.
  - The counter increments each cycle.
  - bus_ack=1: capture bus_rdata, BusErrM=0, next state is DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: captured data=0, BusErrM=1, next state is DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - bus_req=0, MemStallM=0; ReadDataM and BusErrM are valid; the pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally. DONE never starts a new access, so a request is never re-issued for an instruction that has already completed.
- Outside DONE, ReadDataM = 0 and BusErrM = 0.
- bus_ack is ignored outside BUSY.
- Minimum access is 3 cycles: IDLE (stall), BUSY with ack, DONE. A back-to-back access from the next instruction starts in the following IDLE cycle.
- Load formatting in DONE:
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Store formatting:
  - sb: be = 0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - sh: be = 0011 << addr[1:0], wdata = {2{data[15:0]}}.
  - sw: be = 1111.
  - Loads drive be = 1111.
- Reset asserted mid-access: bus_req drops immediately (async) and the transaction is abandoned. The bus slave must treat deasserted bus_req as abort.
- Inputs must stay stable while MemStallM=1; the hazard logic guarantees this.

Decomposition:
- riscv_pkg: mem_state_t enum {IDLE,BUSY,DONE}, plus the FUNCT3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- One sub-module, dmem_lane_fmt (combinational): load extract/extend and store be/wdata generation. It is shared with the instruction-side fetch later.

Test Plan:
- lw 0x0000_0100, ack on the 3rd BUSY cycle with rdata 0xDEAD_BEEF -> MemStallM high for 4 cycles; DONE shows ReadDataM=0xDEAD_BEEF, bus_be=1111.
- lb 0x103, rdata 0x80AA_BBCC -> ReadDataM=0xFFFF_FF80; lbu at the same address -> 0x0000_0080.
- sh 0x202, WriteDataM=0x0000_1234 -> bus_we=1, bus_addr=0x200, bus_be=1100, bus_wdata=0x1234_1234.
- lw 0x101 -> MisalignM=1, MemStallM=0, bus_req never asserted, FSM stays in IDLE.
- With TIMEOUT_CYCLES=4 and no ack -> 4 BUSY cycles, then DONE with BusErrM=1 and ReadDataM=0.
- reset_n low in BUSY -> bus_req=0 asynchronously, IDLE after release.
- Two consecutive lw requests each acked immediately -> 3-cycle accesses back to back, no duplicate requests.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 memory-stage access path.
// Holds the access FSM encoding, funct3 size codes and the alignment rule.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] encodes the access size for loads and stores alike.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-bus req/ack interface between the M-stage initiator and the memory slave.
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: load extract/extend and store byte-enable/replication.
// Purely combinational so it can be reused by the instruction-side fetch.
module dmem_lane_fmt
  import riscv_pkg::*;
(
  input  logic [2:0]  ldFunct3,
  input  logic [1:0]  ldOffset,
  input  logic [31:0] ldWord,
  output logic [31:0] ldData,
  input  logic        stWe,
  input  logic [2:0]  stFunct3,
  input  logic [1:0]  stOffset,
  input  logic [31:0] stData,
  output logic [3:0]  stBe,
  output logic [31:0] stWdata
);

  logic [31:0] ldShifted;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  assign ldShifted = ldWord >> {ldOffset, 3'b000};
  assign ldByte    = ldShifted[7:0];
  assign ldHalf    = ldOffset[1] ? ldWord[31:16] : ldWord[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    ldData = ldWord;
    case (ldFunct3)
      F3_B:    ldData = {{24{ldByte[7]}}, ldByte};
      F3_BU:   ldData = {24'h0, ldByte};
      F3_H:    ldData = {{16{ldHalf[15]}}, ldHalf};
      F3_HU:   ldData = {16'h0, ldHalf};
      default: ldData = ldWord;
    endcase
  end

  always_comb begin
    stBe    = 4'b1111;
    stWdata = stData;
    if (stWe) begin
      case (stFunct3[1:0])
        2'b00: begin
          stBe    = 4'b0001 << stOffset;
          stWdata = {4{stData[7:0]}};
        end
        2'b01: begin
          stBe    = 4'b0011 << stOffset;
          stWdata = {2{stData[15:0]}};
        end
        default: begin
          stBe    = 4'b1111;
          stWdata = stData;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory initiator: runs a req/ack bus transaction per load/store,
// stalls the pipeline until it completes, and formats load/store lanes.
module dmem_access_ctrl
  import riscv_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    MemReqM,
  input  logic                    MemWriteM,
  input  logic [2:0]              Funct3M,
  input  logic [31:0]             ALUResultM,
  input  logic [31:0]             WriteDataM,
  output logic [31:0]             ReadDataM,
  output logic                    MemStallM,
  output logic                    MisalignM,
  output logic                    BusErrM,
  dmem_access_ctrl_if.master      bus
);

  mem_state_t       state;
  logic [TMO_W-1:0] tmoCnt;
  logic [TMO_W-1:0] tmoNext;
  logic [31:0]      rdataQ;
  logic             errQ;
  logic [2:0]       ldFunct3Q;
  logic [1:0]       ldOffsetQ;

  logic             misaligned;
  logic             startAccess;
  logic             timedOut;
  logic [31:0]      ldData;
  logic [3:0]       stBe;
  logic [31:0]      stWdata;

  assign misaligned  = isMisaligned(Funct3M, ALUResultM[1:0]);
  assign startAccess = (state == IDLE) && MemReqM && !misaligned;
  assign MisalignM   = (state == IDLE) && MemReqM && misaligned;
  assign MemStallM   = (state == BUSY) || startAccess;

  assign tmoNext  = tmoCnt + 1'b1;
  assign timedOut = (tmoNext == TMO_W'(TIMEOUT_CYCLES));

  // Load formatting uses the size/offset captured at issue, not the live inputs.
  dmem_lane_fmt u_lane_fmt (
    .ldFunct3 (ldFunct3Q),
    .ldOffset (ldOffsetQ),
    .ldWord   (rdataQ),
    .ldData   (ldData),
    .stWe     (MemWriteM),
    .stFunct3 (Funct3M),
    .stOffset (ALUResultM[1:0]),
    .stData   (WriteDataM),
    .stBe     (stBe),
    .stWdata  (stWdata)
  );

  assign ReadDataM = (state == DONE) ? ldData : 32'h0;
  assign BusErrM   = (state == DONE) && errQ;

  // NOTE: sequential state uses non-blocking assignments; async reset clears every register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_wdata <= 32'h0;
      bus.bus_be    <= 4'h0;
      rdataQ        <= 32'h0;
      errQ          <= 1'b0;
      tmoCnt        <= '0;
      ldFunct3Q     <= F3_W;
      ldOffsetQ     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (startAccess) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= MemWriteM;
            bus.bus_addr  <= {ALUResultM[31:2], 2'b00};
            bus.bus_be    <= stBe;
            bus.bus_wdata <= stWdata;
            tmoCnt        <= '0;
            errQ          <= 1'b0;
            rdataQ        <= 32'h0;
            ldFunct3Q     <= Funct3M;
            ldOffsetQ     <= ALUResultM[1:0];
            state         <= BUSY;
          end
        end
        BUSY: begin
          tmoCnt <= tmoNext;
          // Ack has priority over a timeout landing in the same cycle.
          if (bus.bus_ack) begin
            rdataQ      <= bus.bus_rdata;
            errQ        <= 1'b0;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else if (timedOut) begin
            rdataQ      <= 32'h0;
            errQ        <= 1'b1;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl with a short timeout.
module tb_dmem_access_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemReqM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MisalignM;
  logic        BusErrM;

  dmem_access_ctrl_if busIf ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemStallM  (MemStallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (busIf.master)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   errors    = 0;
  int   reqRises  = 0;
  int   cycleCnt  = 0;
  logic reqPrev   = 1'b0;

  always @(negedge clk) begin
    cycleCnt++;
    if (busIf.bus_req && !reqPrev) reqRises++;
    reqPrev = busIf.bus_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackAfter;
    logic [31:0] expRead;
    logic        expErr;
    int          expStall;
    logic [3:0]  expBe;
    logic [31:0] expBusAddr;
    logic [31:0] expBusWdata;
  } vec_t;

  vec_t vecs [9];

  // Call just after a rising edge. ackAfter = BUSY cycle that carries the ack (0 = never).
  task automatic runAccess(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  int          ackAfter,
    output int          stall,
    output logic [31:0] rd,
    output logic        err,
    output logic [3:0]  be,
    output logic [31:0] bAddr,
    output logic [31:0] bWdata,
    output logic        bWe,
    output logic        done
  );
    int busy;
    MemReqM         = 1'b1;
    MemWriteM       = we;
    Funct3M         = f3;
    ALUResultM      = addr;
    WriteDataM      = wdata;
    busIf.bus_rdata = rdata;
    busIf.bus_ack   = 1'b0;
    stall = 0; busy = 0; done = 1'b0; rd = '0; err = 1'b0;
    be = '0; bAddr = '0; bWdata = '0; bWe = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (MemStallM) stall++;
      if (busIf.bus_req) begin
        busy++;
        if (busy == 1) begin
          be     = busIf.bus_be;
          bAddr  = busIf.bus_addr;
          bWdata = busIf.bus_wdata;
          bWe    = busIf.bus_we;
        end
        busIf.bus_ack = (ackAfter != 0) && (busy == ackAfter);
      end else begin
        busIf.bus_ack = 1'b0;
        if (!MemStallM && stall > 0) begin
          done = 1'b1;
          rd   = ReadDataM;
          err  = BusErrM;
        end
      end
    end
    @(posedge clk);
    #1;
    MemReqM       = 1'b0;
    busIf.bus_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          stall, stallB, c0, r0;
    logic [31:0] rd, bAddr, bWdata;
    logic        err, bWe, done;
    logic [3:0]  be;

    vecs[0] = '{1'b0, F3_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 4, 4'b1111, 32'h0000_0100, 32'h0};
    vecs[1] = '{1'b0, F3_B,  32'h0000_0103, 32'h0,         32'h80AA_BBCC, 1, 32'hFFFF_FF80, 1'b0, 2, 4'b1111, 32'h0000_0100, 32'h0};
    vecs[2] = '{1'b0, F3_BU, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 1, 32'h0000_0080, 1'b0, 2, 4'b1111, 32'h0000_0100, 32'h0};
    vecs[3] = '{1'b1, F3_H,  32'h0000_0202, 32'h0000_1234, 32'h0,         1, 32'h0,         1'b0, 2, 4'b1100, 32'h0000_0200, 32'h1234_1234};
    vecs[4] = '{1'b1, F3_B,  32'h0000_0201, 32'h0000_00AB, 32'h0,         1, 32'h0,         1'b0, 2, 4'b0010, 32'h0000_0200, 32'hABAB_ABAB};
    vecs[5] = '{1'b0, F3_H,  32'h0000_0102, 32'h0,         32'h8001_1234, 2, 32'hFFFF_8001, 1'b0, 3, 4'b1111, 32'h0000_0100, 32'h0};
    vecs[6] = '{1'b0, F3_HU, 32'h0000_0100, 32'h0,         32'h8001_F234, 1, 32'h0000_F234, 1'b0, 2, 4'b1111, 32'h0000_0100, 32'h0};
    vecs[7] = '{1'b0, F3_W,  32'h0000_0300, 32'h0,         32'hDEAD_BEEF, 0, 32'h0,         1'b1, 5, 4'b1111, 32'h0000_0300, 32'h0};
    vecs[8] = '{1'b1, F3_W,  32'h0000_0010, 32'h1122_3344, 32'h0,         2, 32'h0,         1'b0, 3, 4'b1111, 32'h0000_0010, 32'h1122_3344};

    reset_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; Funct3M = F3_W;
    ALUResultM = '0; WriteDataM = '0; busIf.bus_ack = 1'b0; busIf.bus_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst bus_req",   busIf.bus_req,   0);
    check("rst bus_we",    busIf.bus_we,    0);
    check("rst bus_addr",  busIf.bus_addr,  0);
    check("rst bus_wdata", busIf.bus_wdata, 0);
    check("rst bus_be",    busIf.bus_be,    0);
    check("rst ReadDataM", ReadDataM,       0);
    check("rst BusErrM",   BusErrM,         0);
    check("rst MemStallM", MemStallM,       0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      runAccess(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata, vecs[v].rdata,
                vecs[v].ackAfter, stall, rd, err, be, bAddr, bWdata, bWe, done);
      check($sformatf("v%0d done",      v), done,   1);
      check($sformatf("v%0d stall",     v), stall,  vecs[v].expStall);
      check($sformatf("v%0d ReadDataM", v), rd,     vecs[v].expRead);
      check($sformatf("v%0d BusErrM",   v), err,    vecs[v].expErr);
      check($sformatf("v%0d bus_be",    v), be,     vecs[v].expBe);
      check($sformatf("v%0d bus_addr",  v), bAddr,  vecs[v].expBusAddr);
      check($sformatf("v%0d bus_wdata", v), bWdata, vecs[v].expBusWdata);
      check($sformatf("v%0d bus_we",    v), bWe,    vecs[v].we);
    end

    // Misaligned requests: flagged, never stalled, never issued.
    r0 = reqRises;
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = F3_W; ALUResultM = 32'h0000_0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis lw MisalignM", MisalignM,     1);
      check("mis lw MemStallM", MemStallM,     0);
      check("mis lw bus_req",   busIf.bus_req, 0);
    end
    MemWriteM = 1'b1; Funct3M = F3_H; ALUResultM = 32'h0000_0201;
    @(negedge clk);
    check("mis sh MisalignM", MisalignM, 1);
    check("mis sh MemStallM", MemStallM, 0);
    Funct3M = F3_W; ALUResultM = 32'h0000_0202;
    @(negedge clk);
    check("mis sw MisalignM", MisalignM, 1);
    check("mis no request",   reqRises - r0, 0);
    @(posedge clk); #1;
    MemReqM = 1'b0;

    // Back-to-back single-cycle-ack loads: 3 cycles each, one request each.
    r0 = reqRises; c0 = cycleCnt;
    runAccess(1'b0, F3_W, 32'h0000_0400, 32'h0, 32'h0102_0304, 1, stall, rd, err, be, bAddr, bWdata, bWe, done);
    check("b2b first ReadDataM", rd, 32'h0102_0304);
    check("b2b first stall",     stall, 2);
    runAccess(1'b0, F3_W, 32'h0000_0404, 32'h0, 32'hA5A5_5A5A, 1, stallB, rd, err, be, bAddr, bWdata, bWe, done);
    check("b2b second ReadDataM", rd, 32'hA5A5_5A5A);
    check("b2b second stall",     stallB, 2);
    check("b2b requests",         reqRises - r0, 2);
    check("b2b cycles",           cycleCnt - c0, 6);

    // Reset during BUSY drops bus_req without waiting for a clock edge.
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = F3_W; ALUResultM = 32'h0000_0500;
    busIf.bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid in BUSY", busIf.bus_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid bus_req async", busIf.bus_req,  0);
    check("rstmid bus_addr",      busIf.bus_addr, 0);
    MemReqM = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid idle stall", MemStallM,     0);
    check("rstmid idle req",   busIf.bus_req, 0);
    check("rstmid idle read",  ReadDataM,     0);
    @(posedge clk); #1;
    runAccess(1'b0, F3_BU, 32'h0000_0502, 32'h0, 32'h00C3_0000, 1, stall, rd, err, be, bAddr, bWdata, bWe, done);
    check("post-reset ReadDataM", rd, 32'h0000_00C3);
    check("post-reset stall",     stall, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
